// File: rtl/lc3_fetch_unit.sv
// SLC-3 instruction-fetch sequencer: PC -> MAR, memory OE/ready handshake into MDR, then IR.
// Signals Fetch_Done for one cycle when IR holds the freshly fetched instruction.
module lc3_fetch_unit #(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Fetch_Req,
    input  logic              Fetch_Abort,
    input  logic [DATA_W-1:0] PC_In,
    output logic              LD_PC,
    output logic              PC_Inc_Sel,
    output logic [DATA_W-1:0] MAR_Out,
    output logic              Mem_OE,
    input  logic              Mem_Rdy,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] IR_Out,
    output logic              Busy,
    output logic              Fetch_Done,
    output logic              Fetch_Err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAR  = 2'd1,
        S_MEM  = 2'd2,
        S_IR   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [DATA_W-1:0]  mar_r;
    logic [DATA_W-1:0]  mdr_r;
    logic [DATA_W-1:0]  ir_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               done_r;
    logic               err_r;

    logic               ld_pc_s;
    logic               mar_load_s;
    logic               mdr_load_s;
    logic               ir_load_s;
    logic               cnt_clr_s;
    logic               cnt_inc_s;
    logic               err_set_s;
    logic               err_clr_s;
    logic               cnt_last_s;

    assign cnt_last_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Next-state decode and per-register load strobes.
    always_comb begin
        next_state_s = state_r;
        ld_pc_s      = 1'b0;
        mar_load_s   = 1'b0;
        mdr_load_s   = 1'b0;
        ir_load_s    = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Fetch_Req) begin
                    next_state_s = S_MAR;
                    err_clr_s    = 1'b1;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_MAR: begin
                if (Fetch_Abort) begin
                    next_state_s = S_IDLE;
                end else begin
                    ld_pc_s      = 1'b1;
                    mar_load_s   = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = S_MEM;
                end
            end
            S_MEM: begin
                // Abort beats ready, and ready on the final allowed cycle beats timeout.
                if (Fetch_Abort) begin
                    next_state_s = S_IDLE;
                end else if (Mem_Rdy) begin
                    mdr_load_s   = 1'b1;
                    next_state_s = S_IR;
                end else if (cnt_last_s) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_IDLE;
                end else begin
                    cnt_inc_s    = 1'b1;
                    next_state_s = S_MEM;
                end
            end
            S_IR: begin
                ir_load_s    = 1'b1;
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, address/data registers, wait counter and status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= S_IDLE;
            mar_r   <= '0;
            mdr_r   <= '0;
            ir_r    <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (mar_load_s) begin
                mar_r <= PC_In;
            end
            if (mdr_load_s) begin
                mdr_r <= Mem_Data;
            end
            if (ir_load_s) begin
                ir_r <= mdr_r;
            end
            if (cnt_clr_s) begin
                cnt_r <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            done_r <= ir_load_s;
            if (err_clr_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign LD_PC      = ld_pc_s;
    assign PC_Inc_Sel = ld_pc_s;
    assign MAR_Out    = mar_r;
    assign Mem_OE     = (state_r == S_MEM);
    assign IR_Out     = ir_r;
    assign Busy       = (state_r != S_IDLE);
    assign Fetch_Done = done_r;
    assign Fetch_Err  = err_r;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: stimulus pushes expected fetch results, a monitor pops on Fetch_Done.
// A second instance with TIMEOUT=4 exercises the memory timeout path.
module tb_lc3_fetch_unit;

    logic        Clk, Reset;
    logic        Fetch_Req, Fetch_Abort, Mem_Rdy;
    logic [15:0] PC_In, Mem_Data;
    logic        LD_PC, PC_Inc_Sel, Mem_OE, Busy, Fetch_Done, Fetch_Err;
    logic [15:0] MAR_Out, IR_Out;

    logic        req4, rdy4, abort4;
    logic [15:0] pc4, data4;
    logic        ld4, sel4, oe4, busy4, done4, err4;
    logic [15:0] mar4, ir4;

    lc3_fetch_unit #(.TIMEOUT(16), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Fetch_Req(Fetch_Req), .Fetch_Abort(Fetch_Abort),
        .PC_In(PC_In), .LD_PC(LD_PC), .PC_Inc_Sel(PC_Inc_Sel), .MAR_Out(MAR_Out),
        .Mem_OE(Mem_OE), .Mem_Rdy(Mem_Rdy), .Mem_Data(Mem_Data), .IR_Out(IR_Out),
        .Busy(Busy), .Fetch_Done(Fetch_Done), .Fetch_Err(Fetch_Err)
    );

    lc3_fetch_unit #(.TIMEOUT(4), .DATA_W(16)) dut4 (
        .Clk(Clk), .Reset(Reset), .Fetch_Req(req4), .Fetch_Abort(abort4),
        .PC_In(pc4), .LD_PC(ld4), .PC_Inc_Sel(sel4), .MAR_Out(mar4),
        .Mem_OE(oe4), .Mem_Rdy(rdy4), .Mem_Data(data4), .IR_Out(ir4),
        .Busy(busy4), .Fetch_Done(done4), .Fetch_Err(err4)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] mar;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ld_cnt = 0, oe_cnt = 0, oe4_cnt = 0, done4_cnt = 0;
    int          rdy_delay = 0;
    logic [15:0] mem [4];

    assign Mem_Data = mem[MAR_Out[1:0]];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // PC register model: advances one edge after LD_PC is seen.
    initial forever begin
        logic ld;
        @(negedge Clk);
        ld = LD_PC;
        @(posedge Clk);
        #1;
        if (ld) PC_In = PC_In + 16'd1;
    end

    // Memory responder: asserts Mem_Rdy after rdy_delay wait cycles of Mem_OE.
    initial forever begin
        int resp_cnt;
        @(negedge Clk);
        if (Mem_OE) begin
            Mem_Rdy = (resp_cnt >= rdy_delay);
            resp_cnt++;
        end else begin
            Mem_Rdy  = 1'b0;
            resp_cnt = 0;
        end
    end

    // Monitor: counts strobes and scores every Fetch_Done against the queue.
    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (LD_PC) ld_cnt++;
        if (Mem_OE) oe_cnt++;
        if (oe4) oe4_cnt++;
        if (done4) done4_cnt++;
        if (Fetch_Done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ir_out", {16'd0, IR_Out}, {16'd0, e.ir});
                check("mar_out", {16'd0, MAR_Out}, {16'd0, e.mar});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            #1;
            if (sb.size() == 0 && !Busy && !busy4) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
        tick();
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] mar, input int dcyc);
        exp_t e;
        e.ir = ir; e.mar = mar; e.cyc = dcyc;
        sb.push_back(e);
    endtask

    initial begin
        int ld0, oe0, c0;
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
        Reset = 1'b1; Fetch_Req = 1'b0; Fetch_Abort = 1'b0; PC_In = 16'h0000; Mem_Rdy = 1'b0;
        req4 = 1'b0; rdy4 = 1'b0; abort4 = 1'b0; pc4 = 16'h4000; data4 = 16'hBEEF;
        repeat (3) tick();
        @(negedge Clk);
        check("rst_ir", {16'd0, IR_Out}, 32'd0);
        check("rst_mar", {16'd0, MAR_Out}, 32'd0);
        check("rst_flags", {26'd0, LD_PC, Mem_OE, Busy, Fetch_Done, Fetch_Err, PC_Inc_Sel}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Zero-wait fetch at 0x3000.
        PC_In = 16'h3000; rdy_delay = 0; ld0 = ld_cnt; oe0 = oe_cnt;
        c0 = cyc; Fetch_Req = 1'b1; push(16'h1234, 16'h3000, c0 + 4);
        tick(); Fetch_Req = 1'b0;
        wait_idle("t1_idle");
        check("t1_ld_pulses", ld_cnt - ld0, 32'd1);
        check("t1_oe_cycles", oe_cnt - oe0, 32'd1);
        check("t1_busy", {31'd0, Busy}, 32'd0);

        // Five wait cycles; PC has advanced to 0x3001.
        rdy_delay = 5; ld0 = ld_cnt; oe0 = oe_cnt;
        c0 = cyc; Fetch_Req = 1'b1; push(16'h5678, 16'h3001, c0 + 9);
        tick(); Fetch_Req = 1'b0;
        wait_idle("t2_idle");
        check("t2_oe_cycles", oe_cnt - oe0, 32'd6);
        check("t2_err", {31'd0, Fetch_Err}, 32'd0);
        check("t2_pc", {16'd0, PC_In}, 32'h3002);

        // Timeout on the TIMEOUT=4 instance, then the next request clears the flag.
        oe0 = oe4_cnt; req4 = 1'b1;
        tick(); req4 = 1'b0;
        wait_idle("t3_idle");
        check("t3_oe_cycles", oe4_cnt - oe0, 32'd4);
        check("t3_err", {31'd0, err4}, 32'd1);
        check("t3_ir", {16'd0, ir4}, 32'd0);
        check("t3_mar", {16'd0, mar4}, 32'h4000);
        req4 = 1'b1;
        tick(); req4 = 1'b0;
        @(negedge Clk);
        check("t3_err_clr", {31'd0, err4}, 32'd0);
        @(posedge Clk); #1;
        wait_idle("t3_idle2");
        check("t3_no_done", done4_cnt, 32'd0);

        // Abort in S_MAR.
        rdy_delay = 0; ld0 = ld_cnt; Fetch_Req = 1'b1;
        tick(); Fetch_Req = 1'b0; Fetch_Abort = 1'b1;
        @(negedge Clk);
        check("t4_ld_abort", {31'd0, LD_PC}, 32'd0);
        @(posedge Clk); #1;
        Fetch_Abort = 1'b0;
        @(negedge Clk);
        check("t4_busy", {31'd0, Busy}, 32'd0);
        check("t4_ir", {16'd0, IR_Out}, 32'h5678);
        check("t4_mar", {16'd0, MAR_Out}, 32'h3001);
        @(posedge Clk); #1;

        // Abort coincident with Mem_Rdy in S_MEM.
        Fetch_Req = 1'b1;
        tick(); Fetch_Req = 1'b0;
        tick(); Fetch_Abort = 1'b1;
        tick(); Fetch_Abort = 1'b0;
        repeat (4) tick();
        check("t4_ld_total", ld_cnt - ld0, 32'd1);
        check("t4b_ir", {16'd0, IR_Out}, 32'h5678);
        check("t4b_mar", {16'd0, MAR_Out}, 32'h3002);
        check("t4b_busy", {31'd0, Busy}, 32'd0);

        // Back-to-back fetches at 0x3000..0x3003 with Fetch_Req held high.
        PC_In = 16'h3000; ld0 = ld_cnt;
        c0 = cyc; Fetch_Req = 1'b1;
        push(16'h1234, 16'h3000, c0 + 4);
        push(16'h5678, 16'h3001, c0 + 8);
        push(16'h9ABC, 16'h3002, c0 + 12);
        push(16'hDEF0, 16'h3003, c0 + 16);
        repeat (13) tick();
        Fetch_Req = 1'b0;
        wait_idle("t5_idle");
        check("t5_ld_pulses", ld_cnt - ld0, 32'd4);
        check("t5_pc", {16'd0, PC_In}, 32'h3004);

        // Reset during S_MEM while Mem_Rdy is high.
        Fetch_Req = 1'b1;
        tick(); Fetch_Req = 1'b0;
        tick(); Reset = 1'b1;
        tick();
        @(negedge Clk);
        check("t6_ir", {16'd0, IR_Out}, 32'd0);
        check("t6_mar", {16'd0, MAR_Out}, 32'd0);
        check("t6_flags", {26'd0, LD_PC, Mem_OE, Busy, Fetch_Done, Fetch_Err, PC_Inc_Sel}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (5) tick();
        check("t6_ir_after", {16'd0, IR_Out}, 32'd0);
        check("t6_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
Instruction-fetch sequencer directly downstream of the PC register in the SLC-3 datapath.
- On a fetch request from the ISDU, it latches the current PC into MAR and pulses LD_PC so the PC register advances to PC+1.
- It then runs an output-enable/ready handshake with memory and captures the returned word into MDR, then IR.
- Fetch_Done tells the ISDU that IR holds the new instruction.

Parameters:
TIMEOUT, 16, max cycles spent in S_MEM waiting for Mem_Rdy before aborting with Fetch_Err (>=1)
DATA_W, 16, width of address and data paths

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; sampled on rising edge of Clk
Fetch_Req  input  1  ISDU request to start a fetch; sampled only in S_IDLE
Fetch_Abort  input  1  cancel an in-flight fetch (branch/interrupt redirect)
PC_In  input  DATA_W  current PC from PC register output
LD_PC  output  1  PC register load enable (PC <= PC+1 via PCMUX)
PC_Inc_Sel  output  1  forces PCMUX to the PC+1 leg; equal to LD_PC
MAR_Out  output  DATA_W  memory address register
Mem_OE  output  1  memory read strobe
Mem_Rdy  input  1  memory read data valid this cycle
Mem_Data  input  DATA_W  memory read data
IR_Out  output  DATA_W  instruction register
Busy  output  1  high in any state other than S_IDLE
Fetch_Done  output  1  one-cycle pulse; IR_Out holds the new instruction in the same cycle
Fetch_Err  output  1  sticky timeout flag

Behaviour:
- Reset (synchronous) forces the following: state=S_IDLE, MAR=0, MDR=0, IR=0, wait counter=0, Fetch_Done=0, Fetch_Err=0. LD_PC, Mem_OE and Busy are 0. Reset overrides every other input in the same cycle, including mid-fetch; no partial IR update.
- States: S_IDLE, S_MAR, S_MEM, S_IR.
- S_IDLE:
  - Fetch_Req=1 -> S_MAR; Fetch_Err cleared at the same edge.
  - Fetch_Abort is ignored in S_IDLE.
- S_MAR:
  - LD_PC=PC_In_Sel=1 combinationally, unless Fetch_Abort=1 (abort suppresses LD_PC).
  - At the edge: MAR<=PC_In, counter<=0, -> S_MEM.
  - Fetch_Abort=1 -> S_IDLE, MAR unchanged.
- S_MEM:
  - Mem_OE=1.
  - Mem_Rdy=1: MDR<=Mem_Data, -> S_IR.
  - Otherwise counter<=counter+1.
  - If counter==TIMEOUT-1 and Mem_Rdy=0: Fetch_Err<=1, -> S_IDLE.
  - Mem_Rdy on the last allowed cycle wins over timeout.
  - Fetch_Abort=1 -> S_IDLE, with priority over Mem_Rdy and timeout; MDR and IR unchanged, Fetch_Err unchanged. The PC has already advanced; the ISDU owns the redirect.
- S_IR: IR<=MDR, Fetch_Done<=1 (registered), -> S_IDLE. Fetch_Abort is ignored in S_IR; the fetch commits.
- Fetch_Done is high exactly one cycle, in the cycle after S_IR, coincident with the new IR_Out.
- Fetch_Req while Busy is ignored, not queued. Fetch_Req=1 in the cycle Fetch_Done is high starts the next fetch; back-to-back throughput is 1 fetch / 4 cycles with zero-wait memory.
- Latency: Fetch_Req sampled at edge E -> S_MAR during cycle E..E+1; Mem_Rdy in the first S_MEM cycle -> Fetch_Done and IR valid after edge E+3. Each S_MEM wait cycle adds 1.
- Counter width: $clog2(TIMEOUT+1); no wrap, because the FSM leaves S_MEM at TIMEOUT-1.
- MAR_Out holds its value after the fetch until the next S_MAR. Address arithmetic is plain DATA_W-bit; PC 16'hFFFF fetches normally, and the PC register wraps to 0.

Test Plan:
- Reset then PC_In=16'h3000, Fetch_Req pulse, Mem_Rdy=1 in first S_MEM cycle with Mem_Data=16'h1234 -> exactly one LD_PC pulse; MAR_Out=16'h3000; Fetch_Done and IR_Out=16'h1234 three edges after the req edge; Busy low afterwards.
- Mem_Rdy delayed 5 cycles, TIMEOUT=16 -> Mem_OE high for 6 cycles; Fetch_Done 5 cycles later than the zero-wait case; Fetch_Err=0.
- Mem_Rdy never asserted, TIMEOUT=4 -> Mem_OE high exactly 4 cycles; Fetch_Err=1, IR unchanged; next Fetch_Req clears Fetch_Err.
- Fetch_Abort in S_MAR -> LD_PC stays 0, FSM to S_IDLE, IR unchanged. Fetch_Abort coincident with Mem_Rdy in S_MEM -> no Fetch_Done, IR unchanged.
- Fetch_Req held high continuously, zero-wait memory at PCs 16'h3000..16'h3003 -> Fetch_Done every 4th cycle; Fetch_Req during Busy causes no extra LD_PC.
- Reset asserted during S_MEM with Mem_Rdy=1 -> next cycle all outputs at reset values, IR_Out=0, no Fetch_Done.
